// File: rtl/hist_eq_map.sv
`default_nettype none
// ============================================================================
// Module   : hist_eq_map
// Function : Builds an equalisation LUT from a cumulative histogram burst and
//            remaps the following frame through a ping-pong table.
// Revision : 1.0
// ============================================================================
module hist_eq_map #(
    parameter int CNT_W     = 21,
    parameter bit PASS_INIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       pixel_level_data,
    input  logic [CNT_W-1:0] pixel_cnt_num,
    input  logic             pixel_level_vld,
    input  logic             pre_img_vsync,
    input  logic             pre_img_hsync,
    input  logic [7:0]       pre_img_gray,
    output logic             post_img_vsync,
    output logic             post_img_hsync,
    output logic [7:0]       post_img_gray,
    output logic             lut_swap,
    output logic             seq_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DIV     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] c_PH_READ = 4'd0;
    localparam logic [3:0] c_PH_LOAD = 4'd1;
    localparam logic [3:0] c_PH_LAST = 4'd9;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_cdf_ram [0:255];
    logic [7:0]       r_lut     [0:511];

    logic [7:0]       r_expected;
    logic [7:0]       r_k;
    logic [3:0]       r_phase;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_cdf_q;
    logic [CNT_W-1:0] r_rem;
    logic [7:0]       r_num_lo;
    logic [7:0]       r_quo;
    logic             r_bank;
    logic             r_lut_valid;
    logic             r_pending;
    logic             r_seq_err;
    logic             r_vsync_d;
    logic             r_hsync_d;
    logic [7:0]       r_gray_q;

    logic             w_lvl0;
    logic             w_in_seq;
    logic             w_start;
    logic             w_accept;
    logic             w_last;
    logic             w_bad;
    logic             w_div_wr;
    logic             w_div_end;
    logic             w_sop;
    logic             w_swap;
    logic [CNT_W+7:0] w_num;
    logic [CNT_W:0]   w_rem_sh;
    logic             w_ge;
    logic [CNT_W-1:0] w_rem_nxt;
    logic [7:0]       w_quo_nxt;
    logic [7:0]       w_lut_wdata;
    logic [7:0]       w_remap;

    // A level-0 beat starts, restarts or aborts a burst in every state.
    assign w_lvl0    = (pixel_level_data == 8'd0);
    assign w_in_seq  = (pixel_level_data == r_expected);
    assign w_start   = pixel_level_vld && w_lvl0;
    assign w_accept  = pixel_level_vld && (r_state == ST_COLLECT) && w_in_seq;
    assign w_last    = w_accept && (pixel_level_data == 8'd255);
    assign w_bad     = pixel_level_vld &&
                       ((((r_state == ST_IDLE) || (r_state == ST_DONE)) && !w_lvl0) ||
                        ((r_state == ST_COLLECT) && !w_in_seq));
    assign w_div_wr  = (r_state == ST_DIV) && (r_phase == c_PH_LAST);
    assign w_div_end = w_div_wr && (r_k == 8'd255) && !w_start;

    assign w_sop     = pre_img_vsync && !r_vsync_d;
    assign w_swap    = w_sop && r_pending;

    // cdf*255 as (cdf<<8)-cdf; its upper part is always below total.
    assign w_num     = {r_cdf_q, 8'd0} - {8'd0, r_cdf_q};
    assign w_rem_sh  = {r_rem, r_num_lo[7]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_total});
    assign w_rem_nxt = w_ge ? (w_rem_sh[CNT_W-1:0] - r_total) : w_rem_sh[CNT_W-1:0];
    assign w_quo_nxt = {r_quo[6:0], w_ge};
    assign w_lut_wdata = (r_total == '0) ? 8'd0 : w_quo_nxt;

    always_comb begin
        w_remap = 8'd0;
        if (pre_img_hsync) begin
            if (r_lut_valid)
                w_remap = r_lut[{r_bank, pre_img_gray}];
            else if (PASS_INIT)
                w_remap = pre_img_gray;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start)
                    w_state_nxt = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (pixel_level_vld) begin
                    if (w_in_seq) begin
                        if (w_last)
                            w_state_nxt = ST_DIV;
                    end else if (!w_lvl0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DIV: begin
                if (w_start)
                    w_state_nxt = ST_COLLECT;
                else if (w_div_end)
                    w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_expected  <= 8'd0;
            r_k         <= 8'd0;
            r_phase     <= 4'd0;
            r_total     <= '0;
            r_rem       <= '0;
            r_num_lo    <= 8'd0;
            r_quo       <= 8'd0;
            r_bank      <= 1'b0;
            r_lut_valid <= 1'b0;
            r_pending   <= 1'b0;
            r_seq_err   <= 1'b0;
            r_vsync_d   <= 1'b0;
            r_hsync_d   <= 1'b0;
            r_gray_q    <= 8'd0;
        end else begin
            r_vsync_d <= pre_img_vsync;
            r_hsync_d <= pre_img_hsync;
            r_gray_q  <= w_remap;

            if (w_start)
                r_expected <= 8'd1;
            else if (w_accept)
                r_expected <= r_expected + 8'd1;

            if (w_bad)
                r_seq_err <= 1'b1;

            if (w_last) begin
                r_total <= pixel_cnt_num;
                r_k     <= 8'd0;
                r_phase <= c_PH_READ;
            end else if ((r_state == ST_DIV) && !w_start) begin
                if (r_phase == c_PH_LAST) begin
                    r_phase <= c_PH_READ;
                    r_k     <= r_k + 8'd1;
                end else begin
                    r_phase <= r_phase + 4'd1;
                end
                if (r_phase == c_PH_LOAD) begin
                    r_rem    <= w_num[CNT_W+7:8];
                    r_num_lo <= w_num[7:0];
                    r_quo    <= 8'd0;
                end else if (r_phase != c_PH_READ) begin
                    r_rem    <= w_rem_nxt;
                    r_num_lo <= {r_num_lo[6:0], 1'b0};
                    r_quo    <= w_quo_nxt;
                end
            end

            if (w_swap) begin
                r_bank      <= ~r_bank;
                r_lut_valid <= 1'b1;
            end

            if (w_swap || w_start)
                r_pending <= 1'b0;
            else if (w_div_end)
                r_pending <= 1'b1;
        end
    end

    // Table storage is never reset; lut_valid gates its use.
    always_ff @(posedge clk) begin
        if (!rst && (w_start || w_accept))
            r_cdf_ram[pixel_level_data] <= pixel_cnt_num;
        if ((r_state == ST_DIV) && (r_phase == c_PH_READ))
            r_cdf_q <= r_cdf_ram[r_k];
        if (!rst && w_div_wr)
            r_lut[{~r_bank, r_k}] <= w_lut_wdata;
    end

    assign post_img_vsync = r_vsync_d;
    assign post_img_hsync = r_hsync_d;
    assign post_img_gray  = r_gray_q;
    assign lut_swap       = w_swap && !rst;
    assign seq_err        = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_hist_eq_map.sv
`default_nettype none
// ============================================================================
// Module   : tb_hist_eq_map
// Function : Directed/random bench for hist_eq_map against an arithmetic LUT model.
// Revision : 1.0
// ============================================================================
module tb_hist_eq_map;

    localparam int CNT_W = 21;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       pixel_level_data;
    logic [CNT_W-1:0] pixel_cnt_num;
    logic             pixel_level_vld;
    logic             pre_img_vsync;
    logic             pre_img_hsync;
    logic [7:0]       pre_img_gray;
    logic             post_img_vsync;
    logic             post_img_hsync;
    logic [7:0]       post_img_gray;
    logic             lut_swap;
    logic             seq_err;

    hist_eq_map #(.CNT_W(CNT_W), .PASS_INIT(1'b1)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .pixel_level_data (pixel_level_data),
        .pixel_cnt_num    (pixel_cnt_num),
        .pixel_level_vld  (pixel_level_vld),
        .pre_img_vsync    (pre_img_vsync),
        .pre_img_hsync    (pre_img_hsync),
        .pre_img_gray     (pre_img_gray),
        .post_img_vsync   (post_img_vsync),
        .post_img_hsync   (post_img_hsync),
        .post_img_gray    (post_img_gray),
        .lut_swap         (lut_swap),
        .seq_err          (seq_err)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cdf     [256];
    logic [7:0]  new_lut [256];
    logic [7:0]  act_lut [256];
    bit          model_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: map[k] = floor(cdf[k]*255/total), all zero when total is 0.
    task automatic build_model();
        longint unsigned tot;
        tot = cdf[255];
        for (int k = 0; k < 256; k++)
            new_lut[k] = (tot == 0) ? 8'd0 : 8'((longint'(cdf[k]) * 255) / tot);
    endtask

    task automatic rand_hist();
        int unsigned run;
        run = 0;
        for (int k = 0; k < 256; k++) begin
            run += ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
            cdf[k] = run;
        end
    endtask

    task automatic beat(input int lvl, input int unsigned cnt);
        pixel_level_data = 8'(lvl);
        pixel_cnt_num    = CNT_W'(cnt);
        pixel_level_vld  = 1'b1;
        @(negedge clk);
        pixel_level_vld  = 1'b0;
    endtask

    task automatic burst(input int from, input bit gaps);
        for (int k = from; k < 256; k++) begin
            if (gaps && ($urandom_range(0, 3) == 0))
                @(negedge clk);
            beat(k, cdf[k]);
        end
    endtask

    task automatic frame(input bit exp_swap, input string tag);
        pre_img_vsync = 1'b0;
        @(negedge clk);
        pre_img_vsync = 1'b1;
        #1;
        chk(tag, 32'(lut_swap), 32'(exp_swap));
        @(negedge clk);
        if (exp_swap) begin
            act_lut     = new_lut;
            model_valid = 1'b1;
        end
    endtask

    task automatic pix(input int g, input string tag);
        logic [7:0] exp;
        pre_img_gray  = 8'(g);
        pre_img_hsync = 1'b1;
        @(negedge clk);
        exp = model_valid ? act_lut[g] : 8'(g);
        chk(tag, 32'(post_img_gray), 32'(exp));
    endtask

    task automatic pix_rand(input int n, input string tag);
        for (int i = 0; i < n; i++)
            pix($urandom_range(0, 255), tag);
        chk({tag, "_hs"}, 32'(post_img_hsync), 32'd1);
        chk({tag, "_vs"}, 32'(post_img_vsync), 32'd1);
        pre_img_hsync = 1'b0;
        @(negedge clk);
        chk({tag, "_blank"}, 32'(post_img_gray), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pixel_level_data = 8'd0;
        pixel_cnt_num    = '0;
        pixel_level_vld  = 1'b0;
        pre_img_vsync    = 1'b0;
        pre_img_hsync    = 1'b1;
        pre_img_gray     = 8'd99;
        repeat (3) @(negedge clk);
        chk("rst_vsync", 32'(post_img_vsync), 32'd0);
        chk("rst_hsync", 32'(post_img_hsync), 32'd0);
        chk("rst_gray",  32'(post_img_gray),  32'd0);
        chk("rst_swap",  32'(lut_swap),       32'd0);
        chk("rst_err",   32'(seq_err),        32'd0);
        pre_img_hsync = 1'b0;
        rst = 1'b0;

        // First frame before any table: pass-through.
        frame(1'b0, "init_noswap");
        pix(37, "init_37");
        pix_rand(8, "init_pass");

        // Uniform histogram.
        for (int k = 0; k < 256; k++) cdf[k] = 4 * (k + 1);
        burst(0, 1'b0);
        repeat (2600) @(negedge clk);
        build_model();
        chk("uni_m127", 32'(new_lut[127]), 32'd127);
        frame(1'b1, "uni_swap");
        pix(127, "uni_127");
        pix(0, "uni_0");
        pix(255, "uni_255");
        pix_rand(20, "uni_rand");
        frame(1'b0, "uni_once");

        // Two-level image.
        for (int k = 0; k < 256; k++) cdf[k] = (k < 10) ? 0 : ((k < 200) ? 100 : 200);
        burst(0, 1'b1);
        repeat (2600) @(negedge clk);
        build_model();
        frame(1'b1, "two_swap");
        pix(10, "two_10");
        chk("two_10_abs", 32'(post_img_gray), 32'd127);
        pix(200, "two_200");
        chk("two_200_abs", 32'(post_img_gray), 32'd255);
        pix(5, "two_5");
        pix_rand(20, "two_rand");
        chk("two_noerr", 32'(seq_err), 32'd0);

        // Sequence error, then a clean random burst.
        beat(0, 5);
        beat(1, 9);
        beat(3, 12);
        @(negedge clk);
        chk("seq_err", 32'(seq_err), 32'd1);
        frame(1'b0, "seq_noswap");
        pix_rand(10, "seq_old");
        rand_hist();
        burst(0, 1'b1);
        repeat (2600) @(negedge clk);
        build_model();
        frame(1'b1, "seq_swap");
        pix_rand(30, "seq_rand");
        chk("seq_sticky", 32'(seq_err), 32'd1);

        // Abort around k = 100, with a frame start in between.
        rand_hist();
        burst(0, 1'b0);
        repeat (1005) @(negedge clk);
        rand_hist();
        beat(0, cdf[0]);
        frame(1'b0, "abort_noswap");
        pix_rand(10, "abort_old");
        burst(1, 1'b1);
        repeat (2600) @(negedge clk);
        build_model();
        frame(1'b1, "abort_swap");
        pix_rand(30, "abort_rand");

        // Total of zero.
        for (int k = 0; k < 256; k++) cdf[k] = 0;
        burst(0, 1'b0);
        repeat (2600) @(negedge clk);
        build_model();
        frame(1'b1, "zero_swap");
        pix(200, "zero_200");
        chk("zero_200_abs", 32'(post_img_gray), 32'd0);
        pix_rand(20, "zero_rand");

        // Reset in the middle of a division.
        rand_hist();
        burst(0, 1'b0);
        repeat (500) @(negedge clk);
        pre_img_vsync = 1'b0;
        pre_img_hsync = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_vsync", 32'(post_img_vsync), 32'd0);
        chk("mid_rst_hsync", 32'(post_img_hsync), 32'd0);
        chk("mid_rst_gray",  32'(post_img_gray),  32'd0);
        chk("mid_rst_err",   32'(seq_err),        32'd0);
        pre_img_hsync = 1'b0;
        rst = 1'b0;
        model_valid = 1'b0;
        repeat (2600) @(negedge clk);
        frame(1'b0, "mid_rst_noswap");
        pix(37, "mid_rst_37");
        pix_rand(10, "mid_rst_pass");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
